// File: rtl/phy_reg_free_list_pkg.sv
// Shared rename types: default machine configuration and the widths of
// physical-register tags and free-list pointers/counters.
package phy_reg_free_list_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int LOG_REG_NUM  = 32;
    localparam int RENAME_WIDTH = 2;
    localparam int COMMIT_WIDTH = 2;

    localparam int ENTRY_NUM = PHY_REG_NUM - LOG_REG_NUM;
    localparam int PREG_W    = $clog2(PHY_REG_NUM);
    localparam int IDX_W     = $clog2(ENTRY_NUM);
    localparam int CNT_W     = $clog2(ENTRY_NUM) + 1;

    typedef logic [PREG_W-1:0] PRegNumPath;
    typedef logic [IDX_W-1:0]  FreeListIndexPath;
    typedef logic [CNT_W-1:0]  FreeListCountPath;

endpackage

// File: rtl/phy_reg_free_list_prefix_count.sv
// Exclusive prefix popcount of a valid vector: offset[i] is the number of
// set bits below lane i, total is the popcount of the whole vector.
module free_list_prefix_count #(
    parameter int WIDTH = 2,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]         valid,
    output logic [WIDTH-1:0][CW-1:0] offset,
    output logic [CW-1:0]            total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/phy_reg_free_list.sv
// Physical register free list: circular FIFO of the registers not holding
// architectural state, with multi-lane compacted allocate and release.
module phy_reg_free_list
    import phy_reg_free_list_pkg::*;
#(
    parameter int PHY_REG_NUM  = phy_reg_free_list_pkg::PHY_REG_NUM,
    parameter int LOG_REG_NUM  = phy_reg_free_list_pkg::LOG_REG_NUM,
    parameter int RENAME_WIDTH = phy_reg_free_list_pkg::RENAME_WIDTH,
    parameter int COMMIT_WIDTH = phy_reg_free_list_pkg::COMMIT_WIDTH,
    parameter int PREG_W       = $clog2(PHY_REG_NUM),
    parameter int ENTRY_NUM    = PHY_REG_NUM - LOG_REG_NUM,
    parameter int IDX_W        = $clog2(ENTRY_NUM),
    parameter int CNT_W        = $clog2(ENTRY_NUM) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RENAME_WIDTH-1:0]             allocReq,
    output logic                                allocatable,
    output logic [RENAME_WIDTH-1:0][PREG_W-1:0] allocPhyReg,
    input  logic [COMMIT_WIDTH-1:0]             releaseReg,
    input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0] releasePhyReg,
    output logic [CNT_W-1:0]                    freeCount,
    output logic                                allocErr,
    output logic                                releaseErr
);

    localparam int ACW = $clog2(RENAME_WIDTH + 1);
    localparam int RCW = $clog2(COMMIT_WIDTH + 1);

    logic [ENTRY_NUM-1:0][PREG_W-1:0] storage;
    logic [IDX_W-1:0]                 head;
    logic [IDX_W-1:0]                 tail;

    logic [RENAME_WIDTH-1:0][ACW-1:0] allocOff;
    logic [ACW-1:0]                   allocTotal;
    logic [COMMIT_WIDTH-1:0][RCW-1:0] relOff;
    logic [RCW-1:0]                   relTotal;

    logic [ACW-1:0] nAllocAcc;
    logic [CNT_W:0] countSum;
    logic           overflow;

    free_list_prefix_count #(.WIDTH(RENAME_WIDTH), .CW(ACW)) uAllocPrefix (
        .valid  (allocReq),
        .offset (allocOff),
        .total  (allocTotal)
    );

    free_list_prefix_count #(.WIDTH(COMMIT_WIDTH), .CW(RCW)) uRelPrefix (
        .valid  (releaseReg),
        .offset (relOff),
        .total  (relTotal)
    );

    assign allocatable = (freeCount >= CNT_W'(RENAME_WIDTH));

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            allocPhyReg[i] = storage[head + IDX_W'(allocOff[i])];
        end
    end

    // Pop is all-or-nothing on allocatable; an overflowing release drops every push
    always_comb begin
        nAllocAcc = allocatable ? allocTotal : '0;
        countSum  = {1'b0, freeCount} - (CNT_W+1)'(nAllocAcc) + (CNT_W+1)'(relTotal);
        overflow  = (countSum > (CNT_W+1)'(ENTRY_NUM));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            freeCount  <= CNT_W'(ENTRY_NUM);
            allocErr   <= 1'b0;
            releaseErr <= 1'b0;
            for (int k = 0; k < ENTRY_NUM; k++) begin
                storage[k] <= PREG_W'(LOG_REG_NUM + k);
            end
        end else begin
            head <= head + IDX_W'(nAllocAcc);
            if ((allocReq != '0) && !allocatable) begin
                allocErr <= 1'b1;
            end
            if (overflow) begin
                releaseErr <= 1'b1;
                freeCount  <= freeCount - CNT_W'(nAllocAcc);
            end else begin
                freeCount <= countSum[CNT_W-1:0];
                tail      <= tail + IDX_W'(relTotal);
                for (int j = 0; j < COMMIT_WIDTH; j++) begin
                    if (releaseReg[j]) begin
                        storage[tail + IDX_W'(relOff[j])] <= releasePhyReg[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Directed bench for phy_reg_free_list at the default 64/32/2/2 configuration.
module tb_phy_reg_free_list;

    logic            clk;
    logic            rst;
    logic [1:0]      allocReq;
    logic            allocatable;
    logic [1:0][5:0] allocPhyReg;
    logic [1:0]      releaseReg;
    logic [1:0][5:0] releasePhyReg;
    logic [5:0]      freeCount;
    logic            allocErr;
    logic            releaseErr;

    int vectors;
    int miscompares;

    phy_reg_free_list dut (
        .clk           (clk),
        .rst           (rst),
        .allocReq      (allocReq),
        .allocatable   (allocatable),
        .allocPhyReg   (allocPhyReg),
        .releaseReg    (releaseReg),
        .releasePhyReg (releasePhyReg),
        .freeCount     (freeCount),
        .allocErr      (allocErr),
        .releaseErr    (releaseErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        allocReq      = '0;
        releaseReg    = '0;
        releasePhyReg = '0;
        rst           = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (freeCount !== 6'd32) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 32", freeCount);
        end
        vectors++;
        if ({allocatable, allocErr, releaseErr} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 100", {allocatable, allocErr, releaseErr});
        end
    endtask

    task automatic test_alloc_pair();
        do_reset();
        allocReq = 2'b11;
        #1;
        vectors++;
        if (allocPhyReg[0] !== 6'd32 || allocPhyReg[1] !== 6'd33) begin
            miscompares++;
            $display("FAIL pair_grant: got %0d,%0d want 32,33", allocPhyReg[0], allocPhyReg[1]);
        end
        step();
        allocReq = 2'b00;
        #1;
        vectors++;
        if (freeCount !== 6'd30) begin
            miscompares++;
            $display("FAIL pair_count: got %0d want 30", freeCount);
        end
    endtask

    task automatic test_alloc_lane1();
        do_reset();
        allocReq = 2'b10;
        #1;
        vectors++;
        if (allocPhyReg[1] !== 6'd32) begin
            miscompares++;
            $display("FAIL lane1_grant: got %0d want 32", allocPhyReg[1]);
        end
        step();
        allocReq = 2'b00;
        #1;
        vectors++;
        if (freeCount !== 6'd31) begin
            miscompares++;
            $display("FAIL lane1_count: got %0d want 31", freeCount);
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            allocReq = 2'b11;
            #1;
            vectors++;
            if (allocPhyReg[0] !== 6'(32 + 2*c) || allocPhyReg[1] !== 6'(33 + 2*c)) begin
                miscompares++;
                $display("FAIL drain_grant[%0d]: got %0d,%0d want %0d,%0d", c,
                         allocPhyReg[0], allocPhyReg[1], 32 + 2*c, 33 + 2*c);
            end
            step();
        end
        allocReq = 2'b00;
        #1;
        vectors++;
        if (freeCount !== 6'd0 || allocatable !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got count %0d alloc %b want 0 0", freeCount, allocatable);
        end
        allocReq = 2'b11;
        step();
        allocReq = 2'b00;
        #1;
        vectors++;
        if (allocErr !== 1'b1 || freeCount !== 6'd0) begin
            miscompares++;
            $display("FAIL drain_err: got err %b count %0d want 1 0", allocErr, freeCount);
        end
        allocReq = 2'b01;
        #1;
        vectors++;
        if (allocPhyReg[0] !== 6'd32) begin
            miscompares++;
            $display("FAIL drain_head_hold: got %0d want 32", allocPhyReg[0]);
        end
        allocReq = 2'b00;
    endtask

    // Continues from the empty list left by test_drain
    task automatic test_release_refill();
        releaseReg       = 2'b11;
        releasePhyReg[0] = 6'd40;
        releasePhyReg[1] = 6'd7;
        allocReq         = 2'b11;
        #1;
        vectors++;
        if (allocatable !== 1'b0) begin
            miscompares++;
            $display("FAIL refill_bypass: got allocatable %b want 0", allocatable);
        end
        step();
        releaseReg = 2'b00;
        #1;
        vectors++;
        if (freeCount !== 6'd2 || allocatable !== 1'b1) begin
            miscompares++;
            $display("FAIL refill_count: got count %0d alloc %b want 2 1", freeCount, allocatable);
        end
        vectors++;
        if (allocPhyReg[0] !== 6'd40 || allocPhyReg[1] !== 6'd7) begin
            miscompares++;
            $display("FAIL refill_grant: got %0d,%0d want 40,7", allocPhyReg[0], allocPhyReg[1]);
        end
        step();
        allocReq         = 2'b00;
        releaseReg       = 2'b10;
        releasePhyReg[0] = 6'd0;
        releasePhyReg[1] = 6'd9;
        step();
        releaseReg = 2'b00;
        allocReq   = 2'b01;
        #1;
        vectors++;
        if (freeCount !== 6'd1 || allocPhyReg[0] !== 6'd9) begin
            miscompares++;
            $display("FAIL refill_lane1_rel: got count %0d reg %0d want 1 9", freeCount, allocPhyReg[0]);
        end
        allocReq = 2'b00;
    endtask

    task automatic test_wrap();
        do_reset();
        allocReq = 2'b11;
        for (int c = 0; c < 15; c++) step();
        allocReq         = 2'b01;
        releaseReg       = 2'b11;
        releasePhyReg[0] = 6'd50;
        releasePhyReg[1] = 6'd51;
        step();
        allocReq   = 2'b00;
        releaseReg = 2'b00;
        #1;
        vectors++;
        if (freeCount !== 6'd3) begin
            miscompares++;
            $display("FAIL wrap_simul_count: got %0d want 3", freeCount);
        end
        allocReq = 2'b11;
        #1;
        vectors++;
        if (allocPhyReg[0] !== 6'd63 || allocPhyReg[1] !== 6'd50) begin
            miscompares++;
            $display("FAIL wrap_grant: got %0d,%0d want 63,50", allocPhyReg[0], allocPhyReg[1]);
        end
        step();
        allocReq = 2'b01;
        #1;
        vectors++;
        if (allocPhyReg[0] !== 6'd51 || freeCount !== 6'd1) begin
            miscompares++;
            $display("FAIL wrap_head: got reg %0d count %0d want 51 1", allocPhyReg[0], freeCount);
        end
        allocReq = 2'b00;
    endtask

    task automatic test_overflow_reset();
        do_reset();
        releaseReg       = 2'b01;
        releasePhyReg[0] = 6'd5;
        step();
        releaseReg = 2'b00;
        #1;
        vectors++;
        if (releaseErr !== 1'b1 || freeCount !== 6'd32) begin
            miscompares++;
            $display("FAIL ovf_err: got err %b count %0d want 1 32", releaseErr, freeCount);
        end
        allocReq = 2'b11;
        #1;
        vectors++;
        if (allocPhyReg[0] !== 6'd32 || allocPhyReg[1] !== 6'd33) begin
            miscompares++;
            $display("FAIL ovf_dropped: got %0d,%0d want 32,33", allocPhyReg[0], allocPhyReg[1]);
        end
        step();
        releaseReg       = 2'b11;
        releasePhyReg[0] = 6'd11;
        releasePhyReg[1] = 6'd12;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (freeCount !== 6'd32 || allocPhyReg[0] !== 6'd32 || releaseErr !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got count %0d reg %0d rerr %b want 32 32 0",
                     freeCount, allocPhyReg[0], releaseErr);
        end
        allocReq   = 2'b00;
        releaseReg = 2'b00;
        step();
        rst      = 1'b1;
        allocReq = 2'b11;
        #1;
        vectors++;
        if (allocPhyReg[0] !== 6'd32 || allocPhyReg[1] !== 6'd33) begin
            miscompares++;
            $display("FAIL post_reset_grant: got %0d,%0d want 32,33", allocPhyReg[0], allocPhyReg[1]);
        end
        step();
        allocReq = 2'b00;
        #1;
        vectors++;
        if (freeCount !== 6'd30 || allocErr !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_count: got count %0d aerr %b want 30 0", freeCount, allocErr);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        allocReq      = '0;
        releaseReg    = '0;
        releasePhyReg = '0;
        test_reset();
        test_alloc_pair();
        test_alloc_lane1();
        test_drain();
        test_release_refill();
        test_wrap();
        test_overflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
